// File: rtl/alu_arb_pkg.sv
// Shared opcode constants and FSM state encoding for the shared-ALU arbiter.
package alu_arb_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_INV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: searches upward from (last_i + 1) mod 4 for the first
// active request and returns it both one-hot and as an index.
module rr_pick (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       valid_o
);

  logic [1:0] cand;

  // Offset 4 wraps to last_i itself, so the previous winner is tried last.
  always_comb begin
    gnt_o   = '0;
    idx_o   = last_i;
    valid_o = 1'b0;
    cand    = last_i;
    for (int i = 1; i <= 4; i++) begin
      cand = last_i + 2'(i);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
        gnt_o   = 4'b0001 << cand;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Four requesters share one add/sub/shift-add-multiply unit through a
// round-robin arbiter; one operation runs at a time, IDLE -> EXEC -> DONE.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     req,
  input  logic [7:0]     op_flat,
  input  logic [4*W-1:0] a_flat,
  input  logic [4*W-1:0] b_flat,
  output logic [3:0]     gnt,
  output logic           busy,
  output logic [3:0]     done,
  output logic [2*W-1:0] result,
  output logic           err
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         state_q, state_d;
  logic [3:0]     gnt_q, gnt_d;
  logic [1:0]     idx_q, idx_d;
  logic [1:0]     last_q, last_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     done_q, done_d;
  logic [2*W-1:0] result_q, result_d;
  logic           err_q, err_d;

  logic [3:0]     pick_gnt;
  logic [1:0]     pick_idx;
  logic           pick_valid;
  logic [1:0]     op_sel;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;
  logic [2*W-1:0] acc_sum;

  rr_pick u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int k = 0; k < 4; k++) begin
      if (pick_idx == 2'(k)) begin
        op_sel = op_flat[2*k +: 2];
        a_sel  = a_flat[W*k +: W];
        b_sel  = b_flat[W*k +: W];
      end
    end
  end

  assign a_ext   = {{W{1'b0}}, a_q};
  assign b_ext   = {{W{1'b0}}, b_q};
  assign acc_sum = acc_q + (b_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      last_q   <= 2'd3;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Multiply retires one multiplier bit per EXEC cycle; B shifts right while
  // the multiplicand shifts left, so a down-counter alone decides completion.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    last_d   = last_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = '0;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          op_d    = op_sel;
          a_d     = a_sel;
          b_d     = b_sel;
          mcand_d = {{W{1'b0}}, a_sel};
          acc_d   = '0;
          cnt_d   = CW'(W - 1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_ADD: begin
            result_d = a_ext + b_ext;
            err_d    = 1'b0;
            done_d   = gnt_q;
            state_d  = ST_DONE;
          end
          OP_SUB: begin
            result_d = a_ext - b_ext;
            err_d    = 1'b0;
            done_d   = gnt_q;
            state_d  = ST_DONE;
          end
          OP_MUL: begin
            acc_d   = acc_sum;
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == '0) begin
              result_d = acc_sum;
              err_d    = 1'b0;
              done_d   = gnt_q;
              state_d  = ST_DONE;
            end
          end
          OP_INV: begin
            err_d   = 1'b1;
            done_d  = gnt_q;
            state_d = ST_DONE;
          end
        endcase
      end
      ST_DONE: begin
        gnt_d   = '0;
        last_d  = idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt    = gnt_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: vector table plus arbitration/reset corner sequences,
// with every done pulse matched against a queue of expected completions.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic [3:0]     req;
  logic [7:0]     op_flat;
  logic [4*W-1:0] a_flat;
  logic [4*W-1:0] b_flat;
  logic [3:0]     gnt;
  logic           busy;
  logic [3:0]     done;
  logic [2*W-1:0] result;
  logic           err;

  typedef struct {
    logic [3:0]     gnt;
    logic [2*W-1:0] result;
    logic           err;
  } exp_t;

  typedef struct {
    int             idx;
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           err;
    int             lat;
  } vec_t;

  exp_t           expQ[$];
  vec_t           vecs[11];
  int             testsRun;
  int             testsFailed;
  logic           doneSeen;
  logic [2*W-1:0] modelResult;
  logic           modelErr;

  alu_share_arbiter #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .op_flat (op_flat),
    .a_flat  (a_flat),
    .b_flat  (b_flat),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_flat[2*idx +: 2] = op;
    a_flat[W*idx +: W]  = a;
    b_flat[W*idx +: W]  = b;
  endtask

  task automatic pushExp(input logic [3:0] g, input logic [2*W-1:0] r, input logic e);
    exp_t x;
    x.gnt = g;
    x.result = r;
    x.err = e;
    expQ.push_back(x);
  endtask

  // Samples on the falling edge; any done pulse is matched against the queue,
  // otherwise result/err must still hold the last completed values.
  task automatic stepCycle();
    exp_t e;
    @(negedge clk);
    if (done !== 4'b0000) begin
      doneSeen = 1'b1;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'(done), 32'h0);
      end else begin
        e = expQ.pop_front();
        checkOutput("doneOneHot", 32'(done), 32'(e.gnt));
        checkOutput("result", 32'(result), 32'(e.result));
        checkOutput("errFlag", 32'(err), 32'(e.err));
        modelResult = e.result;
        modelErr = e.err;
      end
    end else if (!reset) begin
      checkOutput("resultHold", 32'(result), 32'(modelResult));
      checkOutput("errHold", 32'(err), 32'(modelErr));
    end
  endtask

  task automatic waitDone(input string name, input int limit, input logic [3:0] holdGnt, output int steps);
    doneSeen = 1'b0;
    steps = 0;
    while (!doneSeen && steps < limit) begin
      stepCycle();
      steps++;
      checkOutput("gntHeld", 32'(gnt), 32'(holdGnt));
    end
    checkOutput(name, 32'(doneSeen), 32'h1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    req = '0;
    modelResult = '0;
    modelErr = 1'b0;
    stepCycle();
    checkOutput("rstGnt", 32'(gnt), 32'h0);
    checkOutput("rstDone", 32'(done), 32'h0);
    checkOutput("rstBusy", 32'(busy), 32'h0);
    checkOutput("rstErr", 32'(err), 32'h0);
    checkOutput("rstResult", 32'(result), 32'h0);
    reset = 1'b0;
    stepCycle();
  endtask

  task automatic runVector(input vec_t v);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << v.idx;
    applyStimulus(v.idx, v.op, v.a, v.b);
    req = oh;
    pushExp(oh, v.res, v.err);
    stepCycle();
    checkOutput("gntIssue", 32'(gnt), 32'(oh));
    checkOutput("busyExec", 32'(busy), 32'h1);
    op_flat = 8'($urandom);
    a_flat = 32'($urandom);
    b_flat = 32'($urandom);
    waitDone("vecDone", 40, oh, n);
    checkOutput("latency", 32'(n + 1), 32'(v.lat));
    req = '0;
    stepCycle();
    checkOutput("idleGnt", 32'(gnt), 32'h0);
    checkOutput("idleBusy", 32'(busy), 32'h0);
  endtask

  initial begin
    vec_t rv;
    int n;
    logic [3:0] expG;
    testsRun = 0;
    testsFailed = 0;
    doneSeen = 1'b0;
    reset = 1'b1;
    req = '0;
    op_flat = '0;
    a_flat = '0;
    b_flat = '0;
    modelResult = '0;
    modelErr = 1'b0;

    vecs[0]  = '{0, OP_ADD, 8'd200, 8'd100, 16'd300,   1'b0, 2};
    vecs[1]  = '{2, OP_MUL, 8'd255, 8'd255, 16'd65025, 1'b0, W + 1};
    vecs[2]  = '{1, OP_SUB, 8'd3,   8'd5,   16'hFFFE,  1'b0, 2};
    vecs[3]  = '{3, OP_INV, 8'd9,   8'd4,   16'hFFFE,  1'b1, 2};
    vecs[4]  = '{0, OP_ADD, 8'd255, 8'd255, 16'd510,   1'b0, 2};
    vecs[5]  = '{1, OP_MUL, 8'd0,   8'd77,  16'd0,     1'b0, W + 1};
    vecs[6]  = '{2, OP_MUL, 8'd13,  8'd11,  16'd143,   1'b0, W + 1};
    vecs[7]  = '{3, OP_SUB, 8'd0,   8'd1,   16'hFFFF,  1'b0, 2};
    vecs[8]  = '{0, OP_MUL, 8'd128, 8'd2,   16'd256,   1'b0, W + 1};
    vecs[9]  = '{1, OP_INV, 8'd1,   8'd1,   16'd256,   1'b1, 2};
    vecs[10] = '{2, OP_ADD, 8'd0,   8'd0,   16'd0,     1'b0, 2};

    doReset();
    for (int i = 0; i < 11; i++) runVector(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      rv.idx = int'($urandom_range(0, 3));
      rv.op  = 2'($urandom_range(0, 2));
      rv.a   = W'($urandom);
      rv.b   = W'($urandom);
      rv.err = 1'b0;
      if (rv.op == OP_ADD) rv.res = {8'h00, rv.a} + {8'h00, rv.b};
      else if (rv.op == OP_SUB) rv.res = {8'h00, rv.a} - {8'h00, rv.b};
      else rv.res = {8'h00, rv.a} * {8'h00, rv.b};
      rv.lat = (rv.op == OP_MUL) ? W + 1 : 2;
      runVector(rv);
    end

    // Round robin with all four requesting: 0,1,2,3,0 with an IDLE gap.
    doReset();
    op_flat = '0;
    for (int k = 0; k < 4; k++) applyStimulus(k, OP_ADD, W'(10 * (k + 1)), W'(k + 1));
    for (int g = 0; g < 5; g++) pushExp(4'b0001 << (g % 4), 16'(11 * ((g % 4) + 1)), 1'b0);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      expG = 4'b0001 << (g % 4);
      n = 0;
      do begin
        stepCycle();
        n++;
      end while (gnt == 4'b0000 && n < 10);
      checkOutput("rrGnt", 32'(gnt), 32'(expG));
      checkOutput("rrGap", 32'(n), 32'h1);
      waitDone("rrDone", 10, expG, n);
      if (g == 4) req = '0;
      stepCycle();
      checkOutput("rrIdleGnt", 32'(gnt), 32'h0);
      checkOutput("rrIdleBusy", 32'(busy), 32'h0);
    end

    // Reset in the middle of a multiply; pointer must return to requester 0.
    applyStimulus(2, OP_MUL, 8'd200, 8'd3);
    req = 4'b0100;
    stepCycle();
    checkOutput("mulGnt", 32'(gnt), 32'h4);
    for (int i = 0; i < 3; i++) stepCycle();
    reset = 1'b1;
    modelResult = '0;
    modelErr = 1'b0;
    stepCycle();
    checkOutput("midRstGnt", 32'(gnt), 32'h0);
    checkOutput("midRstDone", 32'(done), 32'h0);
    checkOutput("midRstBusy", 32'(busy), 32'h0);
    checkOutput("midRstErr", 32'(err), 32'h0);
    checkOutput("midRstResult", 32'(result), 32'h0);
    req = '0;
    reset = 1'b0;
    stepCycle();
    stepCycle();
    applyStimulus(0, OP_ADD, 8'd1, 8'd2);
    applyStimulus(2, OP_ADD, 8'd5, 8'd5);
    req = 4'b0101;
    pushExp(4'b0001, 16'd3, 1'b0);
    stepCycle();
    checkOutput("postRstGnt", 32'(gnt), 32'h1);
    waitDone("postRstDone", 10, 4'b0001, n);
    req = '0;
    stepCycle();

    // Requester 1 drops req mid-multiply; requester 3 arrives and waits.
    applyStimulus(1, OP_MUL, 8'd12, 8'd12);
    req = 4'b0010;
    pushExp(4'b0010, 16'd144, 1'b0);
    stepCycle();
    checkOutput("dropGnt", 32'(gnt), 32'h2);
    applyStimulus(3, OP_ADD, 8'd7, 8'd8);
    req = 4'b1000;
    pushExp(4'b1000, 16'd15, 1'b0);
    waitDone("dropDone", 20, 4'b0010, n);
    checkOutput("dropLatency", 32'(n + 1), 32'(W + 1));
    stepCycle();
    checkOutput("waitIdleGnt", 32'(gnt), 32'h0);
    checkOutput("waitIdleBusy", 32'(busy), 32'h0);
    stepCycle();
    checkOutput("lateGnt", 32'(gnt), 32'h8);
    waitDone("lateDone", 10, 4'b1000, n);
    req = '0;
    stepCycle();

    checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
